// File: rtl/dwc_pkg.sv
// Shared types and helpers for the DwC fault monitor.
package dwc_pkg;

   localparam int FC_W = 2;

   typedef enum logic [FC_W-1:0] {
      FC_NONE      = 2'b00,
      FC_TRANSIENT = 2'b01,
      FC_PERMANENT = 2'b10
   } fault_class_t;

   // Any classified fault is reported to the system controller.
   function automatic logic is_alarm(input fault_class_t fc);
      return (fc != FC_NONE);
   endfunction

endpackage

// File: rtl/dwc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module dwc_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX = {W{1'b1}};

   // Count up on inc, stick at all-ones, return to zero on reset or clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= {W{1'b0}};
      end else if (clr) begin
         count <= {W{1'b0}};
      end else if (inc && (count != MAX)) begin
         count <= count + W'(1'b1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/dwc_fault_monitor.sv
// Registers clean DwC results onward, drops corrupted beats, counts errors
// and classifies the fault as transient or permanent by run length.
module dwc_fault_monitor
   import dwc_pkg::*;
#(
   parameter int DATA_W      = 1,
   parameter int PERM_THRESH = 4,
   parameter int CNT_W       = 8
) (
   input  logic              port_clk,
   input  logic              port_rst,
   input  logic              port_in_valid,
   input  logic [DATA_W-1:0] port_in_data,
   input  logic              port_in_error,
   input  logic              port_ack,
   output logic              port_out_valid,
   output logic [DATA_W-1:0] port_out_data,
   output logic              port_alarm,
   output logic [FC_W-1:0]   port_fault_class,
   output logic [CNT_W-1:0]  port_err_count
);

   // Run-length counter only needs to reach the threshold itself.
   localparam int             CW     = $clog2(PERM_THRESH + 1);
   localparam logic [CW-1:0]  THRESH = CW'(PERM_THRESH);

   logic          clean;
   logic          bad;
   logic [CW-1:0] consec;
   logic [CW-1:0] consec_next;
   logic          consec_inc;
   fault_class_t  state;
   fault_class_t  state_next;
   logic          out_valid;
   logic [DATA_W-1:0] out_data;
   logic          alarm;

   assign clean = port_in_valid & ~port_in_error;
   assign bad   = port_in_valid &  port_in_error;

   // Stop incrementing at the threshold so the run clamps there.
   assign consec_inc = bad & (consec != THRESH);

   dwc_sat_counter #(.W(CW)) u_consec (
      .clk   (port_clk),
      .rst   (port_rst),
      .inc   (consec_inc),
      .clr   (clean),
      .count (consec)
   );

   dwc_sat_counter #(.W(CNT_W)) u_err_count (
      .clk   (port_clk),
      .rst   (port_rst),
      .inc   (bad),
      .clr   (1'b0),
      .count (port_err_count)
   );

   // Value the run counter takes at the next edge; idle beats hold the run.
   always_comb begin
      consec_next = consec;
      if (bad) begin
         if (consec == THRESH) begin
            consec_next = THRESH;
         end else begin
            consec_next = consec + CW'(1'b1);
         end
      end else if (clean) begin
         consec_next = {CW{1'b0}};
      end else begin
         consec_next = consec;
      end
   end

   // Fault classification; a bad beat always beats a same-cycle acknowledge.
   always_comb begin
      state_next = state;
      case (state)
         FC_NONE: begin
            if (consec_next == THRESH) begin
               state_next = FC_PERMANENT;
            end else if (bad) begin
               state_next = FC_TRANSIENT;
            end else begin
               state_next = FC_NONE;
            end
         end
         FC_TRANSIENT: begin
            if (consec_next == THRESH) begin
               state_next = FC_PERMANENT;
            end else if (port_ack && !bad) begin
               state_next = FC_NONE;
            end else begin
               state_next = FC_TRANSIENT;
            end
         end
         FC_PERMANENT: begin
            state_next = FC_PERMANENT;
         end
         default: begin
            state_next = FC_NONE;
         end
      endcase
   end

   // Fault state and alarm register, updated together.
   always_ff @(posedge port_clk) begin
      if (port_rst) begin
         state <= FC_NONE;
         alarm <= 1'b0;
      end else begin
         state <= state_next;
         alarm <= is_alarm(state_next);
      end
   end

   // Forward clean beats one cycle later; hold the last clean data otherwise.
   always_ff @(posedge port_clk) begin
      if (port_rst) begin
         out_valid <= 1'b0;
         out_data  <= {DATA_W{1'b0}};
      end else if (clean) begin
         out_valid <= 1'b1;
         out_data  <= port_in_data;
      end else begin
         out_valid <= 1'b0;
         out_data  <= out_data;
      end
   end

   assign port_out_valid   = out_valid;
   assign port_out_data    = out_data;
   assign port_alarm       = alarm;
   assign port_fault_class = state;

endmodule

// File: tb/tb_dwc_fault_monitor.sv
// Self-checking bench for dwc_fault_monitor: directed scenarios followed by
// random traffic, all compared against a run-length/counter reference model.
module tb_dwc_fault_monitor;

   localparam int DATA_W      = 8;
   localparam int PERM_THRESH = 4;
   localparam int CNT_W       = 2;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_error;
   logic              ack;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              alarm;
   logic [1:0]        fault_class;
   logic [CNT_W-1:0]  err_count;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int  m_run;
   int  m_cnt;
   int  m_class;   // 0 none, 1 transient, 2 permanent
   int  m_valid;
   int  m_data;

   dwc_fault_monitor #(
      .DATA_W      (DATA_W),
      .PERM_THRESH (PERM_THRESH),
      .CNT_W       (CNT_W)
   ) dut (
      .port_clk         (clk),
      .port_rst         (rst),
      .port_in_valid    (in_valid),
      .port_in_data     (in_data),
      .port_in_error    (in_error),
      .port_ack         (ack),
      .port_out_valid   (out_valid),
      .port_out_data    (out_data),
      .port_alarm       (alarm),
      .port_fault_class (fault_class),
      .port_err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks = checks + 1;
      if (got != exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference behaviour for one clock edge with the given inputs.
   task automatic model_step(input int r, input int v, input int d,
                             input int e, input int a);
      if (r != 0) begin
         m_run = 0; m_cnt = 0; m_class = 0; m_valid = 0; m_data = 0;
      end else begin
         m_valid = 0;
         if (v != 0 && e == 0) begin
            m_valid = 1;
            m_data  = d;
            m_run   = 0;
         end
         if (v != 0 && e != 0) begin
            m_run = (m_run + 1 > PERM_THRESH) ? PERM_THRESH : m_run + 1;
            m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (m_class != 2) m_class = (m_run == PERM_THRESH) ? 2 : 1;
         end else if (a != 0 && m_class == 1) begin
            m_class = 0;
         end
      end
   endtask

   // Apply one cycle of inputs, advance the model and compare every output.
   task automatic cycle(input int r, input int v, input int d,
                        input int e, input int a);
      @(negedge clk);
      rst      = (r != 0);
      in_valid = (v != 0);
      in_data  = DATA_W'(d);
      in_error = (e != 0);
      ack      = (a != 0);
      @(posedge clk);
      #1;
      model_step(r, v, d, e, a);
      check("out_valid",   int'(out_valid),   m_valid);
      check("out_data",    int'(out_data),    m_data);
      check("fault_class", int'(fault_class), m_class);
      check("alarm",       int'(alarm),       (m_class != 0) ? 1 : 0);
      check("err_count",   int'(err_count),   m_cnt);
   endtask

   initial begin
      int r, v, e, a;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_error = 1'b0; ack = 1'b0;
      m_run = 0; m_cnt = 0; m_class = 0; m_valid = 0; m_data = 0;

      // Reset, then five clean beats
      cycle(1, 0, 0, 0, 0);
      check("reset_class", int'(fault_class), 0);
      check("reset_count", int'(err_count), 0);
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 0, 0, 0);
      check("clean_valid", int'(out_valid), 1);

      // Single bad beat, then acknowledge three cycles later
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 0, 1, 0);
      check("tp2_valid", int'(out_valid), 0);
      check("tp2_data", int'(out_data), 1);
      check("tp2_class", int'(fault_class), 1);
      cycle(0, 1, 7, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      check("tp2_ack", int'(fault_class), 0);

      // bad, bad, idle, bad, bad -> permanent; ack ignored until reset
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 3, 1, 0);
      check("tp3_trans", int'(fault_class), 1);
      cycle(0, 1, 3, 1, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 3, 1, 0);
      check("tp3_still_trans", int'(fault_class), 1);
      cycle(0, 1, 3, 1, 0);
      check("tp3_perm", int'(fault_class), 2);
      for (int i = 0; i < 3; i++) cycle(0, (i == 1) ? 1 : 0, 9, 0, 1);
      check("tp3_ack_ignored", int'(fault_class), 2);
      cycle(1, 0, 0, 0, 0);
      check("tp3_reset", int'(fault_class), 0);

      // Bad beat with ack in the same cycle while transient
      cycle(0, 1, 0, 1, 0);
      cycle(0, 1, 0, 1, 1);
      check("tp4_class", int'(fault_class), 1);
      check("tp4_count", int'(err_count), 2);

      // Six isolated bad beats: counter saturates, class stays transient
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         cycle(0, 1, i, 1, 0);
         check("tp5_count", int'(err_count), (i + 1 > 3) ? 3 : i + 1);
         cycle(0, 1, i + 20, 0, 0);
      end
      check("tp5_class", int'(fault_class), 1);

      // Reset in the middle of a burst discards the run
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 1, 0);
      cycle(0, 1, 0, 1, 0);
      cycle(1, 1, 0, 1, 0);
      check("tp6_reset_alarm", int'(alarm), 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 0);
      check("tp6_not_perm", int'(fault_class), 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 59) == 0) ? 1 : 0;
         v = ($urandom_range(0, 3) != 0) ? 1 : 0;
         e = ($urandom_range(0, 2) == 0) ? 1 : 0;
         a = ($urandom_range(0, 4) == 0) ? 1 : 0;
         cycle(r, v, int'($urandom_range(0, 255)), e, a);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
